// File: rtl/pc_gen_pkg.sv
// Shared types for the fetch-stage PC generator: FSM states, redirect sources
// and the alignment-width helper used by pc_gen_unit and pc_redirect_arb.
package pc_gen_pkg;

   typedef enum logic [1:0] {ST_BOOT, ST_RUN, ST_PEND} state_t;

   typedef enum logic [1:0] {R_NONE, R_BRANCH, R_JALR, R_TRAP} redir_src_t;

   // Number of PC low bits that must be zero for an instruction of this size
   function automatic int calc_align_bits(input int instr_bytes);
      return (instr_bytes == 2) ? 1 : 2;
   endfunction

   localparam int DEFAULT_INSTR_BYTES = 4;
   localparam int ALIGN_BITS          = calc_align_bits(DEFAULT_INSTR_BYTES);

endpackage

// File: rtl/pc_redirect_arb.sv
// Combinational redirect arbiter: trap > JALR > branch, target adders and alignment.
// Optional macro PC_GEN_MISALIGN_TRAP_EN turns misaligned targets into traps.
module pc_redirect_arb
   import pc_gen_pkg::*;
#(
   parameter int                    DATA_WIDTH  = 32,
   parameter logic [DATA_WIDTH-1:0] TRAP_VECTOR = 'h100,
   parameter int                    INSTR_BYTES = 4
) (
   input  logic                  trap_req,
   input  logic                  jalr,
   input  logic                  branch_taken,
   input  logic [DATA_WIDTH-1:0] pc_e,
   input  logic [DATA_WIDTH-1:0] imm_e,
   input  logic [DATA_WIDTH-1:0] base_e,
   output logic                  redir_valid,
   output redir_src_t            redir_src,
   output logic [DATA_WIDTH-1:0] redir_target,
   output logic                  misalign
);

   localparam int                    AB       = calc_align_bits(INSTR_BYTES);
   localparam logic [DATA_WIDTH-1:0] LOW_MASK = DATA_WIDTH'((1 << AB) - 1);

   logic [DATA_WIDTH-1:0] br_tgt;
   logic [DATA_WIDTH-1:0] jalr_tgt;
   logic [DATA_WIDTH-1:0] raw_tgt;

   assign br_tgt   = pc_e + imm_e;
   assign jalr_tgt = (base_e + imm_e) & {{(DATA_WIDTH-1){1'b1}}, 1'b0};

   always_comb begin
      redir_valid  = 1'b0;
      redir_src    = R_NONE;
      raw_tgt      = '0;
      redir_target = '0;
      misalign     = 1'b0;

      if (trap_req) begin
         redir_valid  = 1'b1;
         redir_src    = R_TRAP;
         redir_target = TRAP_VECTOR;
      end else if (jalr) begin
         redir_valid = 1'b1;
         redir_src   = R_JALR;
         raw_tgt     = jalr_tgt;
      end else if (branch_taken) begin
         redir_valid = 1'b1;
         redir_src   = R_BRANCH;
         raw_tgt     = br_tgt;
      end

      // Only computed targets can be misaligned; the trap vector is trusted
      if (redir_src == R_JALR || redir_src == R_BRANCH) begin
`ifdef PC_GEN_MISALIGN_TRAP_EN
         if ((raw_tgt & LOW_MASK) != '0) begin
            misalign     = 1'b1;
            redir_target = TRAP_VECTOR;
         end else begin
            redir_target = raw_tgt;
         end
`else
         redir_target = raw_tgt & ~LOW_MASK;
`endif
      end
   end

endmodule

// File: rtl/pc_gen_unit.sv
// Fetch-stage PC generator: PCF register, imem valid/ready request and redirect buffering.
// Optional macro PC_GEN_MISALIGN_TRAP_EN enables misaligned-target trapping.
module pc_gen_unit
   import pc_gen_pkg::*;
#(
   parameter int                    DATA_WIDTH   = 32,
   parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = '0,
   parameter logic [DATA_WIDTH-1:0] TRAP_VECTOR  = 'h100,
   parameter int                    INSTR_BYTES  = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  stallF,
   input  logic                  imem_ready,
   input  logic                  PCSrcE,
   input  logic                  JalrE,
   input  logic                  TrapReq,
   input  logic [DATA_WIDTH-1:0] PCE,
   input  logic [DATA_WIDTH-1:0] ImmExtE,
   input  logic [DATA_WIDTH-1:0] RegBaseE,
   output logic [DATA_WIDTH-1:0] PCF,
   output logic [DATA_WIDTH-1:0] PCPlus4F,
   output logic                  fetch_valid,
   output logic                  FlushD,
   output logic                  misalign_exc
);

   state_t                state, state_n;
   logic [DATA_WIDTH-1:0] pcf_n;
   logic [DATA_WIDTH-1:0] pend_pc, pend_n;
   logic                  adv;

   logic                  redir_valid;
   redir_src_t            redir_src;
   logic [DATA_WIDTH-1:0] redir_target;
   logic                  redir_misalign;

   pc_redirect_arb #(
      .DATA_WIDTH  (DATA_WIDTH),
      .TRAP_VECTOR (TRAP_VECTOR),
      .INSTR_BYTES (INSTR_BYTES)
   ) u_arb (
      .trap_req     (TrapReq),
      .jalr         (JalrE),
      .branch_taken (PCSrcE),
      .pc_e         (PCE),
      .imm_e        (ImmExtE),
      .base_e       (RegBaseE),
      .redir_valid  (redir_valid),
      .redir_src    (redir_src),
      .redir_target (redir_target),
      .misalign     (redir_misalign)
   );

   assign PCPlus4F = PCF + DATA_WIDTH'(INSTR_BYTES);
   assign adv      = imem_ready & ~stallF;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= ST_BOOT;
         PCF     <= RESET_VECTOR;
         pend_pc <= '0;
      end else begin
         state   <= state_n;
         PCF     <= pcf_n;
         pend_pc <= pend_n;
      end
   end

   always_comb begin
      state_n      = state;
      pcf_n        = PCF;
      pend_n       = pend_pc;
      fetch_valid  = 1'b0;
      FlushD       = 1'b0;
      misalign_exc = 1'b0;

      unique case (state)
         ST_BOOT: begin
            state_n = ST_RUN;
         end
         ST_RUN: begin
            fetch_valid = 1'b1;
            if (redir_valid) begin
               FlushD       = 1'b1;
               misalign_exc = redir_misalign;
               // An un-accepted request keeps PCF stable; park the target instead
               if (imem_ready) begin
                  pcf_n = redir_target;
               end else begin
                  pend_n  = redir_target;
                  state_n = ST_PEND;
               end
            end else if (adv) begin
               pcf_n = PCPlus4F;
            end
         end
         ST_PEND: begin
            fetch_valid = 1'b1;
            if (redir_src == R_TRAP) begin
               FlushD = 1'b1;
               pend_n = TRAP_VECTOR;
               if (imem_ready) begin
                  pcf_n   = TRAP_VECTOR;
                  state_n = ST_RUN;
               end
            end else if (imem_ready) begin
               pcf_n   = pend_pc;
               state_n = ST_RUN;
            end
         end
         default: state_n = ST_BOOT;
      endcase
   end

endmodule

// File: tb/tb_pc_gen_unit.sv
// Self-checking bench for pc_gen_unit: directed scenarios plus random redirects
// against a PC/pending-queue reference model.
module tb_pc_gen_unit;

   localparam logic [31:0] RST_VEC  = 32'h0000_0000;
   localparam logic [31:0] TRAP_VEC = 32'h0000_0100;
   localparam int          IB       = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        stallF = 1'b0, imem_ready = 1'b1;
   logic        PCSrcE = 1'b0, JalrE = 1'b0, TrapReq = 1'b0;
   logic [31:0] PCE = '0, ImmExtE = '0, RegBaseE = '0;
   logic [31:0] PCF, PCPlus4F;
   logic        fetch_valid, FlushD, misalign_exc;

   pc_gen_unit #(
      .DATA_WIDTH   (32),
      .RESET_VECTOR (RST_VEC),
      .TRAP_VECTOR  (TRAP_VEC),
      .INSTR_BYTES  (IB)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .stallF       (stallF),
      .imem_ready   (imem_ready),
      .PCSrcE       (PCSrcE),
      .JalrE        (JalrE),
      .TrapReq      (TrapReq),
      .PCE          (PCE),
      .ImmExtE      (ImmExtE),
      .RegBaseE     (RegBaseE),
      .PCF          (PCF),
      .PCPlus4F     (PCPlus4F),
      .fetch_valid  (fetch_valid),
      .FlushD       (FlushD),
      .misalign_exc (misalign_exc)
   );

   always #5 clk = ~clk;

   int n_assert = 0;
   int n_fail   = 0;

   // Reference model: a PC, a "first cycle after reset" flag, and a queue of
   // at most one parked redirect target.
   logic [31:0] m_pc;
   bit          m_boot;
   logic [31:0] m_pend[$];

   logic        last_flush, last_mis;
   int          flush_cnt;

`ifdef PC_GEN_MISALIGN_TRAP_EN
   localparam bit MIS_EN = 1'b1;
`else
   localparam bit MIS_EN = 1'b0;
`endif

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Target rule from plain arithmetic: priority, wrap add, JALR lsb clear, alignment
   task automatic ref_target(input logic trap, jalr, br, input logic [31:0] pce, imm, base,
                             output bit valid, output logic [31:0] tgt, output bit mis);
      logic [31:0] raw;
      valid = trap | jalr | br;
      mis   = 1'b0;
      raw   = '0;
      if (trap) begin
         tgt = TRAP_VEC;
         return;
      end
      if (jalr) raw = (base + imm) - ((base + imm) % 2);
      else      raw = pce + imm;
      if (raw % IB != 0 && MIS_EN) begin
         mis = 1'b1;
         tgt = TRAP_VEC;
      end else begin
         tgt = raw - (raw % IB);
      end
   endtask

   // One clock: drive at the falling edge, check before the rising edge, advance the model
   task automatic step(input logic trap, jalr, br, ready, stall,
                       input logic [31:0] pce, imm, base);
      bit          v, mis;
      logic [31:0] tgt;
      bit          e_flush, e_mis;
      TrapReq = trap; JalrE = jalr; PCSrcE = br; imem_ready = ready; stallF = stall;
      PCE = pce; ImmExtE = imm; RegBaseE = base;
      #2;
      ref_target(trap, jalr, br, pce, imm, base, v, tgt, mis);
      e_flush = 1'b0;
      e_mis   = 1'b0;
      if (!m_boot) begin
         if (m_pend.size() == 0) begin
            e_flush = v;
            e_mis   = v & mis;
         end else begin
            e_flush = trap;
         end
      end
      chk("pcf", PCF, m_pc);
      chk("pcplus", PCPlus4F, m_pc + IB);
      chk("fetch_valid", 32'(fetch_valid), 32'(!m_boot));
      chk("flushd", 32'(FlushD), 32'(e_flush));
      chk("misalign", 32'(misalign_exc), 32'(e_mis));
      last_flush = FlushD;
      last_mis   = misalign_exc;
      flush_cnt += FlushD ? 1 : 0;
      @(posedge clk);
      if (m_boot) begin
         m_boot = 1'b0;
      end else if (m_pend.size() == 0) begin
         if (v) begin
            if (ready) m_pc = tgt;
            else       m_pend.push_back(tgt);
         end else if (ready && !stall) begin
            m_pc = m_pc + IB;
         end
      end else begin
         if (trap) m_pend[0] = TRAP_VEC;
         if (ready) m_pc = m_pend.pop_front();
      end
      @(negedge clk);
   endtask

   task automatic idle(input logic ready, stall);
      step(1'b0, 1'b0, 1'b0, ready, stall, '0, '0, '0);
   endtask

   task automatic do_reset();
      #1 rst = 1'b0;
      #1;
      m_pc   = RST_VEC;
      m_boot = 1'b1;
      m_pend.delete();
      chk("rst_pcf", PCF, RST_VEC);
      chk("rst_fv", 32'(fetch_valid), 32'h0);
      chk("rst_flush", 32'(FlushD), 32'h0);
      chk("rst_mis", 32'(misalign_exc), 32'h0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      @(negedge clk);
      do_reset();

      // Boot cycle then sequential fetch
      idle(1'b1, 1'b0);
      chk("run_fv", 32'(fetch_valid), 32'h1);
      chk("seq0", PCF, 32'h0);
      idle(1'b1, 1'b0);
      chk("seq4", PCF, 32'h4);
      idle(1'b1, 1'b0);
      chk("seq8", PCF, 32'h8);
      for (int i = 0; i < 20 && m_pc != 32'h20; i++) idle(1'b1, 1'b0);
      chk("at20", PCF, 32'h20);

      // Stall holds the PC
      for (int i = 0; i < 3; i++) begin
         idle(1'b1, 1'b1);
         chk("stall_hold", PCF, 32'h20);
         chk("stall_noflush", 32'(last_flush), 32'h0);
      end
      idle(1'b1, 1'b0);
      chk("resume24", PCF, 32'h24);

      // Taken branch with negative offset, accepted immediately
      step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h40, 32'hFFFF_FFF0, '0);
      chk("br_flush", 32'(last_flush), 32'h1);
      chk("br_pc", PCF, 32'h30);

      // JALR while imem not ready: buffered, single flush
      flush_cnt = 0;
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0, 32'h4, 32'h101);
      chk("jalr_hold1", PCF, 32'h30);
      idle(1'b0, 1'b0);
      chk("jalr_hold2", PCF, 32'h30);
      idle(1'b1, 1'b0);
      chk("jalr_pc", PCF, 32'h104);
      chk("jalr_flushes", 32'(flush_cnt), 32'h1);

      // Trap beats branch
      step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h500, 32'h8, '0);
      chk("trap_pc", PCF, TRAP_VEC);

      // Pending branch overwritten by trap; later branch ignored
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h200, 32'h0, '0);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
      chk("pend_trap_flush", 32'(last_flush), 32'h1);
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h300, 32'h0, '0);
      chk("pend_br_ignored", 32'(last_flush), 32'h0);
      idle(1'b1, 1'b0);
      chk("pend_trap_pc", PCF, TRAP_VEC);

      // Misaligned branch target 0x102
      step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h100, 32'h2, '0);
      chk("mis_exc", 32'(last_mis), 32'(MIS_EN));
      chk("mis_pc", PCF, MIS_EN ? TRAP_VEC : 32'h100);

      // Wrap-around at the top of the address space
      step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, '0, 32'h4, 32'hFFFF_FFF8);
      chk("wrap_top", PCF, 32'hFFFF_FFFC);
      chk("wrap_plus", PCPlus4F, 32'h0);
      idle(1'b1, 1'b0);
      chk("wrap_zero", PCF, 32'h0);

      // Reset while a redirect is pending discards it
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h80, 32'h0, '0);
      do_reset();
      idle(1'b1, 1'b0);
      idle(1'b1, 1'b0);
      chk("rst_pend_drop", PCF, 32'h4);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         logic [31:0] pce, imm, base;
         pce  = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
         imm  = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 64) : $urandom;
         base = $urandom;
         step($urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0,
              $urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0,
              $urandom_range(0, 3) == 0, pce, imm, base);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/pc_gen_unit.md
Name: pc_gen_unit

Overview:
Parametrised fetch-stage program-counter generator.
- Holds PCF; produces PCPlus4F; issues fetch requests to instruction memory over a valid/ready handshake.
- Arbitrates redirects: trap > JALR > branch.
- Computes branch and JALR targets internally from Execute-stage operands.
- Buffers a redirect that arrives while a fetch request is un-accepted and applies it later, so no redirect is lost.

Parameters:
DATA_WIDTH, 32, width of PC, immediates and targets
RESET_VECTOR, 32'h0000_0000, PCF value after reset
TRAP_VECTOR, 32'h0000_0100, PC loaded on trap or on misaligned target (optional feature)
INSTR_BYTES, 4, sequential increment; must be 2 or 4

Ports:
clk  in  1  clock
rst  in  1  reset; one clock; reset is asynchronous and active-low
stallF  in  1  hazard-unit stall of fetch
imem_ready  in  1  instruction memory accepts the current request
PCSrcE  in  1  conditional branch in E resolved taken
JalrE  in  1  JALR in E
TrapReq  in  1  trap/exception request
PCE  in  DATA_WIDTH  PC of the E-stage instruction
ImmExtE  in  DATA_WIDTH  sign-extended immediate from E
RegBaseE  in  DATA_WIDTH  rs1 value for JALR
PCF  out  DATA_WIDTH  current fetch PC (imem address)
PCPlus4F  out  DATA_WIDTH  PCF + INSTR_BYTES, modulo 2^DATA_WIDTH
fetch_valid  out  1  fetch request valid
FlushD  out  1  one-cycle pulse when a redirect is accepted
misalign_exc  out  1  one-cycle pulse on a misaligned target (optional feature)

Behaviour:
- Reset (rst=0, asynchronous):
  - PCF=RESET_VECTOR, state=ST_BOOT, fetch_valid=0, FlushD=0, misalign_exc=0, pending register cleared.
- ST_BOOT:
  - Lasts exactly one cycle after reset deasserts; fetch_valid=0; next state ST_RUN.
  - Redirect inputs are ignored in ST_BOOT.
- ST_RUN:
  - fetch_valid=1.
  - adv = imem_ready & ~stallF.
  - No redirect and adv: PCF<=PCPlus4F next cycle.
  - No redirect and ~adv: PCF holds.
- Redirect targets:
  - Branch target = PCE+ImmExtE.
  - JALR target = (RegBaseE+ImmExtE) with bit0 cleared.
  - Trap target = TRAP_VECTOR.
  - All additions wrap modulo 2^DATA_WIDTH.
- Redirect priority: TrapReq > JalrE > PCSrcE.
- Redirect in ST_RUN:
  - FlushD=1 combinationally in the same cycle.
  - stallF is overridden by a redirect.
  - imem_ready=1 (request complete): PCF<=target next cycle; stay ST_RUN.
  - imem_ready=0: PCF must stay stable while fetch_valid & ~imem_ready. Capture target into pend_pc; go to ST_PEND.
- ST_PEND:
  - fetch_valid=1; PCF held.
  - When imem_ready=1: PCF<=pend_pc; go to ST_RUN.
  - FlushD does not re-pulse when pend_pc is applied.
  - New TrapReq: replaces pend_pc with TRAP_VECTOR and pulses FlushD. If imem_ready=1 in the same cycle, PCF<=TRAP_VECTOR directly.
  - New branch/JALR: ignored (older redirect already flushed them).
- Wrap-around: PCF=2^DATA_WIDTH−INSTR_BYTES advances to 0 with no flag.
- Reset mid-pending: pending redirect is discarded; PCF=RESET_VECTOR.

Optional Feature:
Macro PC_GEN_MISALIGN_TRAP_EN.
- Defined:
  - Misaligned branch/JALR target is detected when target[1:0]!=0 (INSTR_BYTES=4) or target[0]!=0 (INSTR_BYTES=2).
  - Such a target is replaced by TRAP_VECTOR.
  - misalign_exc pulses with FlushD.
- Not defined:
  - Target low bits are forced to zero (same widths as above).
  - misalign_exc is tied 0.

Decomposition:
- pc_gen_pkg:
  - state_t enum {ST_BOOT, ST_RUN, ST_PEND}
  - redir_src_t enum {R_NONE, R_BRANCH, R_JALR, R_TRAP}
  - localparam ALIGN_BITS derived from INSTR_BYTES
- One sub-module, pc_redirect_arb (combinational):
  - Priority select, target adders, JALR bit0 clear, misalign check.
  - Outputs redir_valid, redir_src, redir_target.
- pc_gen_unit holds the FSM, PCF and pend_pc registers.

Test Plan:
- Reset release, imem_ready=1, no stalls -> cycle0 fetch_valid=0 PCF=0x0; then PCF 0x0,0x4,0x8 on successive cycles.
- stallF=1 for 3 cycles at PCF=0x20 -> PCF holds 0x20, FlushD=0; resumes 0x24.
- PCSrcE=1, PCE=0x40, ImmExtE=0xFFFFFFF0, imem_ready=1 -> FlushD pulse; next PCF=0x30.
- JALR with RegBaseE=0x101, ImmExtE=0x4, imem_ready=0 for 2 cycles -> PCF held, single FlushD pulse; PCF=0x104 the cycle after imem_ready=1.
- TrapReq together with PCSrcE=1 -> PCF=TRAP_VECTOR; while pending, TrapReq overwrites and a branch is ignored.
- Branch target 0x102 -> with PC_GEN_MISALIGN_TRAP_EN: PCF=TRAP_VECTOR, misalign_exc=1; without it: PCF=0x100, misalign_exc=0. PCF=0xFFFFFFFC advances to 0x0.
